// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
//   arb_state_t : arbiter FSM states
//   DefDataW    : default byte width toward the transmitter
package uart_pkg;

  localparam int unsigned DefDataW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWaitDone,
    StLocked
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and transmitter-side signals around the arbiter.
//   req_valid/req_data/req_last/req_ready : per-requester byte streams
//   tx_start/tx_data/tx_busy/tx_done      : shared transmitter handshake
//   grant_valid/grant_id/lock_timeout     : ownership status
// master: arbiter side. slave: requesters + transmitter side.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter int unsigned DataW  = DefDataW
);
  localparam int unsigned IdW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [NumReq-1:0]       req_valid;
  logic [NumReq*DataW-1:0] req_data;
  logic [NumReq-1:0]       req_last;
  logic [NumReq-1:0]       req_ready;
  logic                    tx_start;
  logic [DataW-1:0]        tx_data;
  logic                    tx_busy;
  logic                    tx_done;
  logic                    grant_valid;
  logic [IdW-1:0]          grant_id;
  logic                    lock_timeout;

  modport master (
    input  req_valid, req_data, req_last, tx_busy, tx_done,
    output req_ready, tx_start, tx_data, grant_valid, grant_id, lock_timeout
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy, tx_done,
    input  req_ready, tx_start, tx_data, grant_valid, grant_id, lock_timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
//   req_i     : request vector
//   ptr_i     : highest-priority index
//   gnt_oh_o  : one-hot of the chosen request
//   gnt_idx_o : index of the chosen request
//   any_o     : at least one request is set
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] ptr_i,
  output logic [N-1:0]   gnt_oh_o,
  output logic [IdW-1:0] gnt_idx_o,
  output logic           any_o
);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_i) + k) % N;
      if (!any_o && req_i[idx]) begin
        any_o         = 1'b1;
        gnt_idx_o     = IdW'(idx);
        gnt_oh_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NumReq byte streams.
// A granted requester keeps the transmitter until it sends a last byte, reaches
// MaxBurst bytes, or stays idle for LockTimeout cycles while locked.
//   clk, rst_ : clock, synchronous active-low reset
//   bus       : requester valid/ready streams, transmitter start/busy/done,
//               grant status and lock_timeout pulse
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned DataW       = DefDataW,
  parameter int unsigned MaxBurst    = 16,
  parameter int unsigned LockTimeout = 1024
) (
  input logic               clk,
  input logic               rst_,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned IdW    = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned BurstW = $clog2(MaxBurst + 1);
  localparam int unsigned IdleW  = (LockTimeout > 1) ? $clog2(LockTimeout) : 1;
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MaxBurst);
  localparam logic [IdleW-1:0]  IdleMax  = IdleW'(LockTimeout - 1);

  arb_state_t        state_q, state_d;
  logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]    grant_id_q, grant_id_d;
  logic              grant_valid_q, grant_valid_d;
  logic              last_flag_q, last_flag_d;
  logic [BurstW-1:0] burst_cnt_q, burst_cnt_d;
  logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;

  logic [NumReq-1:0] pick_oh;
  logic [IdW-1:0]    pick_idx;
  logic              pick_any;
  logic              unused_pick_oh;

  logic [IdW-1:0]    next_ptr;
  logic              gnt_req_valid;
  logic              gnt_req_last;
  logic [DataW-1:0]  gnt_req_data;
  logic              drop_grant;

  rr_pick #(
    .N   (NumReq),
    .IdW (IdW)
  ) u_rr_pick (
    .req_i     (bus.req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  assign unused_pick_oh = ^pick_oh;

  assign gnt_req_valid = bus.req_valid[grant_id_q];
  assign gnt_req_last  = bus.req_last[grant_id_q];
  assign gnt_req_data  = bus.req_data[grant_id_q*DataW +: DataW];
  assign next_ptr      = (32'(grant_id_q) + 1 == NumReq) ? '0 : grant_id_q + 1'b1;

  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    grant_id_d       = grant_id_q;
    grant_valid_d    = grant_valid_q;
    last_flag_d      = last_flag_q;
    burst_cnt_d      = burst_cnt_q;
    idle_cnt_d       = idle_cnt_q;
    drop_grant       = 1'b0;
    bus.req_ready    = '0;
    bus.tx_start     = 1'b0;
    bus.tx_data      = '0;
    bus.lock_timeout = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_id_d    = pick_idx;
          grant_valid_d = 1'b1;
          burst_cnt_d   = '0;
          state_d       = StLoad;
        end
      end
      StLoad: begin
        // Accept and launch in the same cycle so each accepted byte maps to one start.
        if (!bus.tx_busy && gnt_req_valid) begin
          bus.tx_start              = 1'b1;
          bus.req_ready[grant_id_q] = 1'b1;
          bus.tx_data               = gnt_req_data;
          last_flag_d               = gnt_req_last;
          burst_cnt_d               = burst_cnt_q + 1'b1;
          state_d                   = StWaitDone;
        end
      end
      StWaitDone: begin
        if (bus.tx_done) begin
          if (last_flag_q || burst_cnt_q == BurstMax) begin
            drop_grant = 1'b1;
          end else if (gnt_req_valid) begin
            state_d = StLoad;
          end else begin
            idle_cnt_d = '0;
            state_d    = StLocked;
          end
        end
      end
      StLocked: begin
        if (gnt_req_valid) begin
          state_d = StLoad;
        end else if (idle_cnt_q == IdleMax) begin
          bus.lock_timeout = 1'b1;
          drop_grant       = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (drop_grant) begin
      rr_ptr_d      = next_ptr;
      grant_valid_d = 1'b0;
      state_d       = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      last_flag_q   <= 1'b0;
      burst_cnt_q   <= '0;
      idle_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      last_flag_q   <= last_flag_d;
      burst_cnt_q   <= burst_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte-stream requesters (command responder, status reporter, debug echo, ...).
- Uses round-robin arbitration with message lock. Once a requester is granted, it keeps the transmitter until it flags the last byte, hits MAX_BURST, or stalls past LOCK_TIMEOUT.
- Sits between the requester valid/ready interfaces and the transmitter's start/busy/done interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width to the transmitter.
- MAX_BURST, 16, max bytes per grant before forced release (>=1).
- LOCK_TIMEOUT, 1024, idle cycles while locked before forced release (>=1).

Ports:
- clk  in  1  system clock
- rst_  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester byte available
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i at [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  byte is last of message
- req_ready  out  NUM_REQ  byte accepted (one-hot pulse)
- tx_start  out  1  one-cycle start pulse to transmitter
- tx_data  out  DATA_W  byte to transmitter, valid with tx_start
- tx_busy  in  1  transmitter is sending a frame
- tx_done  in  1  one-cycle pulse after the stop bit completes
- grant_valid  out  1  a requester currently owns the transmitter
- grant_id  out  $clog2(NUM_REQ)  index of the owner
- lock_timeout  out  1  one-cycle pulse on forced timeout release

Behaviour:
- Single clock domain. Reset is synchronous and active-low on rst_; it is sampled only at the posedge of clk.
- Reset values: req_ready=0, tx_start=0, tx_data=0, grant_valid=0, grant_id=0, lock_timeout=0, state=IDLE, rr_ptr=0, burst_cnt=0, idle_cnt=0.
- Requester rule: once req_valid[i] is high, req_valid[i], req_data and req_last hold until req_ready[i].
- States: IDLE, LOAD, WAIT_DONE, LOCKED.
- IDLE:
  - If any req_valid bit is set, pick the first set bit at or after rr_ptr (wrapping).
  - Latch grant_id, set grant_valid=1, clear burst_cnt, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - When !tx_busy && req_valid[g], assert tx_start=1, req_ready[g]=1 and tx_data=req_data[g] in the same cycle.
  - Latch last_flag=req_last[g], increment burst_cnt, go to WAIT_DONE.
  - If tx_busy is high, wait in LOAD with no pulses.
- WAIT_DONE, on tx_done:
  - Release if last_flag=1 or burst_cnt==MAX_BURST. Release means rr_ptr=(g+1) mod NUM_REQ, grant_valid=0, go to IDLE.
  - Otherwise go to LOAD if req_valid[g]=1.
  - Otherwise go to LOCKED with idle_cnt=0.
- LOCKED:
  - If req_valid[g]=1, go to LOAD.
  - Otherwise increment idle_cnt. When idle_cnt==LOCK_TIMEOUT-1, pulse lock_timeout and release as above.
- Latency: valid in IDLE at cycle 0 -> tx_start and req_ready at cycle 1 (if tx_busy=0). Back-to-back bytes within a grant: tx_done at cycle n -> next tx_start at cycle n+1.
- Exactly one tx_start per accepted byte. req_ready is never asserted for a requester other than grant_id.
- tx_done in IDLE, LOAD or LOCKED is ignored.
- A requester deasserting req_valid without being accepted is a protocol violation; the arbiter's behaviour in that case is not required.
- Reset mid-frame returns to IDLE with rr_ptr=0. A later tx_done for the abandoned frame is ignored.
- burst_cnt width: $clog2(MAX_BURST+1). idle_cnt width: $clog2(LOCK_TIMEOUT).

Decomposition:
- uart_pkg: arb_state_t enum (IDLE, LOAD, WAIT_DONE, LOCKED) and shared DATA_W default constant.
- Sub-module rr_pick: combinational round-robin picker (req vector + pointer -> one-hot + index + any). Unit-testable alone.

Test Plan:
- Reset, then req_valid=4'b0001, data 8'hA5, last=1 -> tx_start at cycle 1 with tx_data=8'hA5, req_ready=4'b0001; after tx_done, grant_valid=0 and rr_ptr=1.
- All four requesters valid, each single-byte message (last=1) -> grant order 0,1,2,3, then 0 again; exactly 4 tx_start pulses.
- Requester 2 sends 3-byte message 11,22,33 while requester 1 is valid -> bytes 11,22,33 are transmitted consecutively before any byte from requester 1.
- MAX_BURST=16, requester 0 sends 20 bytes with no last, requester 3 valid -> release after byte 16, requester 3 is served, then requester 0 resumes with byte 17.
- Requester 1 sends a byte (last=0) then drops valid -> LOCKED; after LOCK_TIMEOUT cycles lock_timeout pulses once, grant_valid=0, and a pending requester 2 is granted next.
- tx_busy held high while in LOAD for 50 cycles -> no tx_start until tx_busy falls; synchronous reset asserted in WAIT_DONE -> all outputs 0 on the next edge, and a subsequent tx_done is ignored.
